// File: rtl/ex_pkg.sv
// Types and constants shared by execute, the result buffer and writeback.
// Result width follows `SIMD_DATA_WIDTH when the core defines it, else 64.
`ifndef SIMD_DATA_WIDTH
`define SIMD_DATA_WIDTH 64
`endif

package ex_pkg;
  localparam int EX_DATA_W = `SIMD_DATA_WIDTH;
  localparam int EX_RD_W   = 5;

  localparam logic [1:0] SIMD_CTL_SCALAR = 2'b00;
  localparam logic [1:0] SIMD_CTL_SIMD32 = 2'b01;
  localparam logic [1:0] SIMD_CTL_SIMD16 = 2'b10;

  typedef struct packed {
    logic [EX_DATA_W-1:0] data;
    logic [EX_RD_W-1:0]   rd;
    logic                 wen;
    logic [1:0]           simd_ctl;
  } ex_result_t;
endpackage

// File: rtl/ex_fwd_match.sv
// Forwarding lookup over the two buffered entries; the youngest matching entry wins.
// Instantiated only when EX_RESULT_FWD_EN is defined.
module ex_fwd_match #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic [1:0]             ent_vld_i,
  input  logic [1:0]             ent_wen_i,
  input  logic [1:0][RD_W-1:0]   ent_rd_i,
  input  logic [1:0][DATA_W-1:0] ent_data_i,
  input  logic                   young_idx_i,
  input  logic [RD_W-1:0]        rs_i,
  output logic                   hit_o,
  output logic [DATA_W-1:0]      data_o
);
  logic [1:0] match;

  // x0 is hardwired zero, so it never forwards
  for (genvar i = 0; i < 2; i++) begin : g_cmp
    assign match[i] = ent_vld_i[i] & ent_wen_i[i] & (ent_rd_i[i] == rs_i) & (|rs_i);
  end

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (match[young_idx_i]) begin
      hit_o  = 1'b1;
      data_o = ent_data_i[young_idx_i];
    end else if (match[~young_idx_i]) begin
      hit_o  = 1'b1;
      data_o = ent_data_i[~young_idx_i];
    end
  end
endmodule

// File: rtl/ex_result_buffer.sv
// Two-entry FIFO between execute and writeback; flushable on redirect.
// Define EX_RESULT_FWD_EN to add the decode forwarding lookup (fwd_rs/fwd_hit/fwd_data).
module ex_result_buffer
  import ex_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W,
  parameter int RD_W   = EX_RD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic [1:0]        in_simd_ctl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [1:0]        out_simd_ctl,
  input  logic [RD_W-1:0]   fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [1:0]        simd_ctl;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // in_ready depends only on registered count, so no out_ready -> in_ready path
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush) begin
      // stale entry contents are left in place; count=0 hides them
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        ent_q[wr_ptr_q] <= '{data: in_data, rd: in_rd, wen: in_wen, simd_ctl: in_simd_ctl};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign out_data     = ent_q[rd_ptr_q].data;
  assign out_rd       = ent_q[rd_ptr_q].rd;
  assign out_wen      = ent_q[rd_ptr_q].wen;
  assign out_simd_ctl = ent_q[rd_ptr_q].simd_ctl;

`ifdef EX_RESULT_FWD_EN
  logic [1:0]             ent_vld, ent_wen;
  logic [1:0][RD_W-1:0]   ent_rd;
  logic [1:0][DATA_W-1:0] ent_data;

  for (genvar i = 0; i < 2; i++) begin : g_ent
    assign ent_vld[i]  = (count_q == CNT_FULL) ||
                         ((count_q != '0) && (rd_ptr_q == PTR_W'(i)));
    assign ent_wen[i]  = ent_q[i].wen;
    assign ent_rd[i]   = ent_q[i].rd;
    assign ent_data[i] = ent_q[i].data;
  end

  ex_fwd_match #(.DATA_W(DATA_W), .RD_W(RD_W)) u_fwd (
    .ent_vld_i   (ent_vld),
    .ent_wen_i   (ent_wen),
    .ent_rd_i    (ent_rd),
    .ent_data_i  (ent_data),
    .young_idx_i (~wr_ptr_q),
    .rs_i        (fwd_rs),
    .hit_o       (fwd_hit),
    .data_o      (fwd_data)
  );
`else
  logic unused_fwd_rs;
  assign unused_fwd_rs = ^fwd_rs;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif
endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed self-checking bench for ex_result_buffer (forwarding checks adapt to EX_RESULT_FWD_EN).
module tb_ex_result_buffer;
  localparam int DATA_W = 64;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, in_wen, out_valid, out_ready, out_wen, fwd_hit;
  logic [DATA_W-1:0] in_data, out_data, fwd_data;
  logic [RD_W-1:0]   in_rd, out_rd, fwd_rs;
  logic [1:0]        in_simd_ctl, out_simd_ctl;

  int checks = 0;
  int errors = 0;

  ex_result_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .in_wen(in_wen), .in_simd_ctl(in_simd_ctl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wen(out_wen), .out_simd_ctl(out_simd_ctl),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RD_W-1:0] rd, input logic [63:0] d,
                       input logic w, input logic [1:0] s);
    in_valid    = v;
    in_rd       = rd;
    in_data     = d;
    in_wen      = w;
    in_simd_ctl = s;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; fwd_rs = '0;
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_rd",    64'(out_rd),    64'd0);
    chk("rst_fwd_hit",   64'(fwd_hit),   64'd0);
    chk("rst_fwd_data",  fwd_data,       64'd0);
    rst_n = 1'b1;

    // Fill with A then B while writeback stalls
    tick();
    drive(1'b1, 5'd3, 64'h1111, 1'b1, 2'b01);
    tick();
    chk("fill1_out_valid", 64'(out_valid), 64'd1);
    chk("fill1_out_data",  out_data,       64'h1111);
    chk("fill1_in_ready",  64'(in_ready),  64'd1);
    drive(1'b1, 5'd4, 64'h2222, 1'b1, 2'b10);
    tick();
    chk("full_in_ready",  64'(in_ready),     64'd0);
    chk("full_out_rd",    64'(out_rd),       64'd3);
    chk("full_out_simd",  64'(out_simd_ctl), 64'd1);
    drive(1'b1, 5'd9, 64'hDEAD, 1'b1, 2'b00);  // refused: buffer full
    tick();
    chk("full_hold_rd",   64'(out_rd),       64'd3);
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    out_ready = 1'b1;
    chk("drainA_data",    out_data,          64'h1111);
    tick();
    chk("drainB_valid",   64'(out_valid),    64'd1);
    chk("drainB_rd",      64'(out_rd),       64'd4);
    chk("drainB_data",    out_data,          64'h2222);
    chk("drainB_simd",    64'(out_simd_ctl), 64'd2);
    tick();
    chk("drained_valid",  64'(out_valid),    64'd0);
    chk("drained_ready",  64'(in_ready),     64'd1);

    // Streaming: simultaneous push and pop keeps one entry
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i + 1), 64'h100 + 64'(i), 1'b1, 2'b00);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data",  out_data,       64'h100 + 64'(i));
      chk("stream_ready", 64'(in_ready),  64'd1);
    end
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    tick();
    chk("stream_end_valid", 64'(out_valid), 64'd0);

    // wen=0 entry still occupies a slot and drains
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 64'h77, 1'b0, 2'b00);
    tick();
    chk("nowen_valid", 64'(out_valid), 64'd1);
    chk("nowen_wen",   64'(out_wen),   64'd0);
    chk("nowen_rd",    64'(out_rd),    64'd7);
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    out_ready = 1'b1;
    tick();
    chk("nowen_drained", 64'(out_valid), 64'd0);

    // Flush at count 2 with a push attempt and pop
    out_ready = 1'b0;
    drive(1'b1, 5'd8, 64'hD, 1'b1, 2'b00);
    tick();
    drive(1'b1, 5'd9, 64'hE, 1'b1, 2'b00);
    tick();
    chk("preflush_full", 64'(in_ready), 64'd0);
    drive(1'b1, 5'd10, 64'hC, 1'b1, 2'b00);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    tick();
    chk("flush_no_C",  64'(out_valid), 64'd0);

    // Flush at count 1 drops a same-cycle accepted push
    out_ready = 1'b0;
    drive(1'b1, 5'd11, 64'h6, 1'b1, 2'b00);
    tick();
    drive(1'b1, 5'd12, 64'hC0, 1'b1, 2'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    chk("flush1_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 5'd13, 64'hF, 1'b1, 2'b00);
    tick();
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    chk("postflush_data", out_data,     64'hF);
    chk("postflush_rd",   64'(out_rd),  64'd13);
    out_ready = 1'b1;
    tick();
    chk("postflush_empty", 64'(out_valid), 64'd0);

    // Forwarding: two entries for r5, youngest must win
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 64'hA, 1'b1, 2'b00);
    tick();
    drive(1'b1, 5'd5, 64'hB, 1'b1, 2'b00);
    tick();
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    fwd_rs = 5'd5;
    #1;
`ifdef EX_RESULT_FWD_EN
    chk("fwd_hit_r5",  64'(fwd_hit), 64'd1);
    chk("fwd_data_r5", fwd_data,     64'hB);
    fwd_rs = 5'd0;
    #1;
    chk("fwd_hit_r0",  64'(fwd_hit), 64'd0);
    fwd_rs = 5'd6;
    #1;
    chk("fwd_hit_r6",  64'(fwd_hit), 64'd0);
`else
    chk("nofwd_hit",  64'(fwd_hit), 64'd0);
    chk("nofwd_data", fwd_data,     64'd0);
`endif

    // Async reset between clock edges with count 2
    chk("pre_areset_full", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_ready", 64'(in_ready),  64'd1);
    chk("areset_data",  out_data,       64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_areset_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
